// File: rtl/if_id_pkg.sv
// Shared IF/ID definitions: path widths, instruction field positions and the
// stage entry record. Used by the skid stage, its interface and the ID stage.
package if_id_pkg;

  localparam int PC_W    = 32;
  localparam int INSTR_W = 32;
  localparam int RS_W    = 4;
  localparam int IMM_W   = 26;

  localparam int OP_HI   = 31;
  localparam int OP_LO   = 30;
  localparam int FUNC_HI = 29;
  localparam int FUNC_LO = 28;
  localparam int I_BIT   = 27;
  localparam int V_BIT   = 26;
  localparam int RS1_HI  = 25;
  localparam int RS1_LO  = 22;
  localparam int RS2_HI  = 21;
  localparam int RS2_LO  = 18;
  localparam int RS3_HI  = 17;
  localparam int RS3_LO  = 14;

  typedef struct packed {
    logic               valid;
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } if_entry_t;

  localparam logic [INSTR_W-1:0] NOP_INSTR = '0;

endpackage

// File: rtl/if_id_skid_stage_if.sv
// Fetch-to-decode handshake bundle. The stage takes the slave view; the
// surrounding fetch/decode logic (or a bench) takes the master view.
interface if_id_skid_stage_if;
  import if_id_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [PC_W-1:0]    pc_in;
  logic [INSTR_W-1:0] instr_in;
  logic               out_valid;
  logic               out_ready;
  logic [PC_W-1:0]    pc;
  logic [1:0]         op;
  logic [1:0]         func;
  logic               I;
  logic               V;
  logic [RS_W-1:0]    RS1;
  logic [RS_W-1:0]    RS2;
  logic [RS_W-1:0]    RS3;
  logic [IMM_W-1:0]   imm;

  modport slave (
    input  in_valid, pc_in, instr_in, out_ready,
    output in_ready, out_valid, pc, op, func, I, V, RS1, RS2, RS3, imm
  );

  modport master (
    output in_valid, pc_in, instr_in, out_ready,
    input  in_ready, out_valid, pc, op, func, I, V, RS1, RS2, RS3, imm
  );

endinterface

// File: rtl/instr_field_decode.sv
// Purely combinational instruction field slicer; shared with the ID stage.
// The immediate deliberately overlaps the register-specifier fields.
module instr_field_decode
  import if_id_pkg::*;
(
  input  logic [INSTR_W-1:0] instr,
  output logic [1:0]         op,
  output logic [1:0]         func,
  output logic               I,
  output logic               V,
  output logic [RS_W-1:0]    RS1,
  output logic [RS_W-1:0]    RS2,
  output logic [RS_W-1:0]    RS3,
  output logic [IMM_W-1:0]   imm
);

  assign op   = instr[OP_HI:OP_LO];
  assign func = instr[FUNC_HI:FUNC_LO];
  assign I    = instr[I_BIT];
  assign V    = instr[V_BIT];
  assign RS1  = instr[RS1_HI:RS1_LO];
  assign RS2  = instr[RS2_HI:RS2_LO];
  assign RS3  = instr[RS3_HI:RS3_LO];
  assign imm  = instr[IMM_W-1:0];

endmodule

// File: rtl/if_id_skid_stage.sv
// Elastic IF/ID stage: head + skid entry, registered in_ready, flush, NOP
// outputs when empty. Define IFID_PERF_EN to add stall/flush counters.
module if_id_skid_stage
  import if_id_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  if_id_skid_stage_if.slave   bus
`ifdef IFID_PERF_EN
  ,
  output logic [31:0]         stall_cnt,
  output logic [31:0]         flush_cnt
`endif
);

  if_entry_t          head_reg;
  if_entry_t          skid_reg;
  if_entry_t          new_entry;
  logic               accept;
  logic               pop;
  logic [INSTR_W-1:0] dec_instr;

  // in_ready depends only on the skid register, never on out_ready
  assign bus.in_ready  = !skid_reg.valid;
  assign bus.out_valid = head_reg.valid;
  assign accept        = bus.in_valid && !skid_reg.valid;
  assign pop           = head_reg.valid && bus.out_ready;

  always_comb begin
    new_entry       = '0;
    new_entry.valid = 1'b1;
    new_entry.pc    = bus.pc_in;
    new_entry.instr = bus.instr_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_reg <= '0;
      skid_reg <= '0;
    end else if (flush) begin
      head_reg.valid <= 1'b0;
      skid_reg.valid <= 1'b0;
    end else if (pop) begin
      // a full skid implies in_ready = 0, so no accept can coincide here
      if (skid_reg.valid) begin
        head_reg       <= skid_reg;
        skid_reg.valid <= 1'b0;
      end else if (accept) begin
        head_reg <= new_entry;
      end else begin
        head_reg.valid <= 1'b0;
      end
    end else if (accept) begin
      if (!head_reg.valid) begin
        head_reg <= new_entry;
      end else begin
        skid_reg <= new_entry;
      end
    end
  end

  // Empty stage presents the NOP encoding so decode sees no register reads
  assign dec_instr = head_reg.valid ? head_reg.instr : NOP_INSTR;
  assign bus.pc    = head_reg.valid ? head_reg.pc : '0;

  instr_field_decode u_decode (
    .instr (dec_instr),
    .op    (bus.op),
    .func  (bus.func),
    .I     (bus.I),
    .V     (bus.V),
    .RS1   (bus.RS1),
    .RS2   (bus.RS2),
    .RS3   (bus.RS3),
    .imm   (bus.imm)
  );

`ifdef IFID_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (head_reg.valid && !bus.out_ready && (stall_cnt != 32'hFFFF_FFFF)) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if (flush && (head_reg.valid || skid_reg.valid) && (flush_cnt != 32'hFFFF_FFFF)) begin
        flush_cnt <= flush_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_if_id_skid_stage.sv
// Directed self-checking bench for if_id_skid_stage; counter checks are
// included when IFID_PERF_EN is defined.
module tb_if_id_skid_stage;
  import if_id_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic flush;
`ifdef IFID_PERF_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
`endif

  if_id_skid_stage_if bus();

  int n_checks = 0;
  int n_fails  = 0;
  int cyc      = 0;

  if_id_skid_stage dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .bus       (bus)
`ifdef IFID_PERF_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Apply one cycle of inputs, step past the edge, and log the transaction
  task automatic drive(input logic v, input logic [31:0] p, input logic [31:0] ins,
                       input logic rdy, input logic fl);
    bus.in_valid  = v;
    bus.pc_in     = p;
    bus.instr_in  = ins;
    bus.out_ready = rdy;
    flush         = fl;
    @(posedge clk);
    #1;
    $display("cyc %0d in_v=%b pc_in=%h rdy=%b flush=%b -> out_v=%b pc=%h op=%0d imm=%h in_ready=%b",
             cyc, v, p, rdy, fl, bus.out_valid, bus.pc, bus.op, bus.imm, bus.in_ready);
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0;
    bus.in_valid = 1'b0; bus.pc_in = '0; bus.instr_in = '0; bus.out_ready = 1'b1;
    #2;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fails++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    n_checks++; if (bus.pc !== 32'h0) begin n_fails++; $display("FAIL reset_pc: got %h expected 0", bus.pc); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fails++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
    n_checks++; if ({bus.op, bus.func, bus.I, bus.V, bus.imm} !== 32'h0) begin n_fails++; $display("FAIL reset_fields: got %h expected 0", {bus.op, bus.func, bus.I, bus.V, bus.imm}); end
`ifdef IFID_PERF_EN
    n_checks++; if ({stall_cnt, flush_cnt} !== 64'h0) begin n_fails++; $display("FAIL reset_counters: got %h expected 0", {stall_cnt, flush_cnt}); end
`endif
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_stream();
    logic [31:0] ins;
    for (int i = 0; i < 4; i++) begin
      ins = 32'h4000_0000 + 32'h111 * i;
      drive(1'b1, 32'(4 * i), ins, 1'b1, 1'b0);
      n_checks++; if (bus.out_valid !== 1'b1 || bus.pc !== 32'(4 * i)) begin n_fails++; $display("FAIL stream_pc%0d: got v=%b pc=%h expected v=1 pc=%h", i, bus.out_valid, bus.pc, 32'(4 * i)); end
      n_checks++; if (bus.imm !== ins[25:0] || bus.op !== 2'd1) begin n_fails++; $display("FAIL stream_word%0d: got op=%0d imm=%h expected op=1 imm=%h", i, bus.op, bus.imm, ins[25:0]); end
      n_checks++; if (bus.in_ready !== 1'b1) begin n_fails++; $display("FAIL stream_in_ready%0d: got %b expected 1", i, bus.in_ready); end
    end
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    n_checks++; if (bus.out_valid !== 1'b0 || bus.pc !== 32'h0) begin n_fails++; $display("FAIL stream_drain: got v=%b pc=%h expected v=0 pc=0", bus.out_valid, bus.pc); end
  endtask

  task automatic test_field_decode();
    drive(1'b1, 32'h100, 32'hB6C8_C000, 1'b0, 1'b0);
    n_checks++; if (bus.op !== 2'd2) begin n_fails++; $display("FAIL dec_op: got %0d expected 2", bus.op); end
    n_checks++; if (bus.func !== 2'd3) begin n_fails++; $display("FAIL dec_func: got %0d expected 3", bus.func); end
    n_checks++; if (bus.I !== 1'b0 || bus.V !== 1'b1) begin n_fails++; $display("FAIL dec_iv: got I=%b V=%b expected I=0 V=1", bus.I, bus.V); end
    n_checks++; if (bus.RS1 !== 4'hB) begin n_fails++; $display("FAIL dec_rs1: got %h expected b", bus.RS1); end
    n_checks++; if (bus.RS2 !== 4'h2) begin n_fails++; $display("FAIL dec_rs2: got %h expected 2", bus.RS2); end
    n_checks++; if (bus.RS3 !== 4'h3) begin n_fails++; $display("FAIL dec_rs3: got %h expected 3", bus.RS3); end
    n_checks++; if (bus.imm !== 26'h2C8_C000) begin n_fails++; $display("FAIL dec_imm: got %h expected 2c8c000", bus.imm); end
    n_checks++; if (bus.pc !== 32'h100) begin n_fails++; $display("FAIL dec_pc: got %h expected 100", bus.pc); end
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    n_checks++; if ({bus.op, bus.RS1, bus.imm} !== 32'h0) begin n_fails++; $display("FAIL dec_empty_nop: got %h expected 0", {bus.op, bus.RS1, bus.imm}); end
  endtask

  task automatic test_backpressure();
    drive(1'b1, 32'h200, 32'h1111_1111, 1'b1, 1'b0);
    n_checks++; if (bus.pc !== 32'h200 || bus.in_ready !== 1'b1) begin n_fails++; $display("FAIL bp_a: got pc=%h rdy=%b expected pc=200 rdy=1", bus.pc, bus.in_ready); end
    drive(1'b1, 32'h204, 32'h2222_2222, 1'b0, 1'b0);
    n_checks++; if (bus.pc !== 32'h200 || bus.in_ready !== 1'b0) begin n_fails++; $display("FAIL bp_hold1: got pc=%h rdy=%b expected pc=200 rdy=0", bus.pc, bus.in_ready); end
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 32'h208, 32'h3333_3333, 1'b0, 1'b0);
      n_checks++; if (bus.pc !== 32'h200 || bus.in_ready !== 1'b0) begin n_fails++; $display("FAIL bp_stall%0d: got pc=%h rdy=%b expected pc=200 rdy=0", k, bus.pc, bus.in_ready); end
    end
    drive(1'b1, 32'h208, 32'h3333_3333, 1'b1, 1'b0);
    n_checks++; if (bus.pc !== 32'h204 || bus.imm !== 26'h222_2222 || bus.in_ready !== 1'b1) begin n_fails++; $display("FAIL bp_b: got pc=%h imm=%h rdy=%b expected pc=204 imm=2222222 rdy=1", bus.pc, bus.imm, bus.in_ready); end
    drive(1'b1, 32'h208, 32'h3333_3333, 1'b1, 1'b0);
    n_checks++; if (bus.pc !== 32'h208 || bus.imm !== 26'h333_3333) begin n_fails++; $display("FAIL bp_c: got pc=%h imm=%h expected pc=208 imm=3333333", bus.pc, bus.imm); end
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fails++; $display("FAIL bp_drain: got v=%b expected 0 (duplicate word)", bus.out_valid); end
  endtask

  task automatic test_flush();
    drive(1'b1, 32'h300, 32'hC000_0001, 1'b0, 1'b0);
    drive(1'b1, 32'h304, 32'hC000_0002, 1'b0, 1'b0);
    n_checks++; if (bus.in_ready !== 1'b0 || bus.pc !== 32'h300) begin n_fails++; $display("FAIL flush_full: got rdy=%b pc=%h expected rdy=0 pc=300", bus.in_ready, bus.pc); end
    drive(1'b1, 32'h308, 32'hC000_0003, 1'b0, 1'b1);
    n_checks++; if (bus.out_valid !== 1'b0 || bus.pc !== 32'h0) begin n_fails++; $display("FAIL flush_empty: got v=%b pc=%h expected v=0 pc=0", bus.out_valid, bus.pc); end
    n_checks++; if ({bus.op, bus.imm} !== 28'h0 || bus.in_ready !== 1'b1) begin n_fails++; $display("FAIL flush_fields: got fields=%h rdy=%b expected 0 rdy=1", {bus.op, bus.imm}, bus.in_ready); end
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fails++; $display("FAIL flush_reappear: got v=%b pc=%h expected v=0", bus.out_valid, bus.pc); end
    drive(1'b1, 32'h30C, 32'hC000_0004, 1'b1, 1'b0);
    drive(1'b1, 32'h310, 32'hC000_0005, 1'b0, 1'b1);
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fails++; $display("FAIL flush_in_word: got v=%b pc=%h expected v=0", bus.out_valid, bus.pc); end
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fails++; $display("FAIL flush_in_word2: got v=%b pc=%h expected v=0", bus.out_valid, bus.pc); end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 32'h400, 32'h8000_0001, 1'b0, 1'b0);
    drive(1'b1, 32'h404, 32'h8000_0002, 1'b0, 1'b0);
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fails++; $display("FAIL arst_full: got rdy=%b expected 0", bus.in_ready); end
    #3;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    #1;
    n_checks++; if (bus.out_valid !== 1'b0 || bus.pc !== 32'h0) begin n_fails++; $display("FAIL arst_immediate: got v=%b pc=%h expected v=0 pc=0", bus.out_valid, bus.pc); end
    n_checks++; if (bus.in_ready !== 1'b1 || bus.op !== 2'd0) begin n_fails++; $display("FAIL arst_ready: got rdy=%b op=%0d expected rdy=1 op=0", bus.in_ready, bus.op); end
    @(posedge clk); #1;
    rst = 1'b0;
    drive(1'b1, 32'h408, 32'h8000_0003, 1'b1, 1'b0);
    n_checks++; if (bus.out_valid !== 1'b1 || bus.pc !== 32'h408) begin n_fails++; $display("FAIL arst_first_accept: got v=%b pc=%h expected v=1 pc=408", bus.out_valid, bus.pc); end
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
  endtask

`ifdef IFID_PERF_EN
  task automatic test_perf();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    drive(1'b1, 32'h500, 32'h4000_0005, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    n_checks++; if (stall_cnt !== 32'd5) begin n_fails++; $display("FAIL perf_stall: got %0d expected 5", stall_cnt); end
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
    n_checks++; if (flush_cnt !== 32'd1 || stall_cnt !== 32'd5) begin n_fails++; $display("FAIL perf_flush: got flush=%0d stall=%0d expected 1 5", flush_cnt, stall_cnt); end
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
    n_checks++; if (flush_cnt !== 32'd1) begin n_fails++; $display("FAIL perf_empty_flush: got %0d expected 1", flush_cnt); end
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_field_decode();
    test_backpressure();
    test_flush();
    test_async_reset();
`ifdef IFID_PERF_EN
    test_perf();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
